// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a six-digit multiplexed 7-segment bus.
// Samples the scanned enables/segments, rejects short scan-transition
// glitches, decodes each lit digit back to BCD and publishes whole frames.
module seg_scan_decoder #(
  parameter int STABLE_CYC  = 4,        // legal range 2..255
  parameter bit ENB_ACT_LOW = 1'b1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  i_seg_enb,
  input  logic        i_seg_dp,
  input  logic [6:0]  i_seg,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic [5:0]  o_blank,
  output logic        o_frame_vld,
  output logic        o_err_seg,
  output logic        o_err_enb,
  output logic        o_stall
);

  typedef enum logic {SCAN, PUBLISH} state_t;

  localparam logic [7:0]  STABLE_V  = 8'(STABLE_CYC);
  // The write into the shadow happens on the edge where the counter
  // becomes STABLE_CYC-1, so the strobe looks one count earlier.
  localparam logic [7:0]  CAPTURE_V = 8'(STABLE_CYC - 2);
  localparam logic [19:0] TIMEOUT_V = 20'(TIMEOUT_CYC);
  localparam logic [19:0] STALL_MAX = '1;

  // Decode {a..g} to {bad, blank, bcd}.
  function automatic logic [5:0] decode(input logic [6:0] s);
    unique case (s)
      7'b1111110: decode = {2'b00, 4'h0};
      7'b0110000: decode = {2'b00, 4'h1};
      7'b1101101: decode = {2'b00, 4'h2};
      7'b1111001: decode = {2'b00, 4'h3};
      7'b0110011: decode = {2'b00, 4'h4};
      7'b1011011: decode = {2'b00, 4'h5};
      7'b1011111: decode = {2'b00, 4'h6};
      7'b1110000: decode = {2'b00, 4'h7};
      7'b1111111: decode = {2'b00, 4'h8};
      7'b1111011: decode = {2'b00, 4'h9};
      7'b0000000: decode = {2'b01, 4'hF};
      default:    decode = {2'b10, 4'hE};
    endcase
  endfunction

  logic [5:0]  enb_r;
  logic        dp_r;
  logic [6:0]  seg_r;
  logic [13:0] prev;
  logic [7:0]  stable_cnt;
  logic [19:0] stall_cnt;
  state_t      state;
  logic [5:0]  mask;
  logic [5:0]  mask_nxt;
  logic [23:0] sh_digits;
  logic [5:0]  sh_dp;
  logic [5:0]  sh_blank;
  logic [2:0]  slot;
  logic        is_onehot;
  logic        is_multi;
  logic        changed;
  logic        capture;
  logic        publish;
  logic [5:0]  dec;

  // Input register; enables are normalised to active-high here.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would chain the stages within one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enb_r <= '0;
      dp_r  <= 1'b0;
      seg_r <= '0;
      prev  <= '0;
    end else begin
      enb_r <= ENB_ACT_LOW ? ~i_seg_enb : i_seg_enb;
      dp_r  <= i_seg_dp;
      seg_r <= i_seg;
      prev  <= {enb_r, dp_r, seg_r};
    end
  end

  assign changed = ({enb_r, dp_r, seg_r} != prev);
  assign capture = !changed && (stable_cnt == CAPTURE_V);

  // Stability counter: restart on any change, saturate at STABLE_CYC so
  // a held value is captured exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
    end else if (changed) begin
      stable_cnt <= '0;
    end else if (stable_cnt != STABLE_V) begin
      stable_cnt <= stable_cnt + 8'd1;
    end
  end

  // Classify the enable pattern, pick the slot, and form the next mask.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    slot = '0;
    for (int k = 0; k < 6; k++) begin
      if (enb_r[k]) slot = 3'(k);
    end
    is_onehot = (enb_r != '0) && ((enb_r & (enb_r - 6'd1)) == '0);
    is_multi  = (enb_r != '0) && !is_onehot;
    dec       = decode(seg_r);
    publish   = (state == SCAN) && (mask == 6'h3F);
    mask_nxt  = publish ? 6'h00 : mask;
    if (capture && is_onehot) mask_nxt = mask_nxt | enb_r;
  end

  // Control FSM: accumulate slots in SCAN, copy and pulse in PUBLISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SCAN;
      mask        <= '0;
      sh_digits   <= '0;
      sh_dp       <= '0;
      sh_blank    <= '0;
      o_digits    <= 24'hFFFFFF;
      o_dp        <= '0;
      o_blank     <= 6'h3F;
      o_frame_vld <= 1'b0;
      o_err_seg   <= 1'b0;
      o_err_enb   <= 1'b0;
    end else begin
      o_frame_vld <= 1'b0;
      o_err_seg   <= 1'b0;
      o_err_enb   <= 1'b0;
      mask        <= mask_nxt;

      unique case (state)
        SCAN: begin
          if (publish) begin
            o_digits    <= sh_digits;
            o_dp        <= sh_dp;
            o_blank     <= sh_blank;
            o_frame_vld <= 1'b1;
            state       <= PUBLISH;
          end
        end
        PUBLISH: state <= SCAN;
        default: state <= SCAN;
      endcase

      // Shadow writes read-before-write against the copy above, so a
      // capture on the publish cycle lands in the next frame.
      if (capture && is_onehot) begin
        sh_digits[{slot, 2'b00} +: 4] <= dec[3:0];
        sh_dp[slot]                   <= dp_r;
        sh_blank[slot]                <= dec[4];
        o_err_seg                     <= dec[5];
      end
      if (capture && is_multi) o_err_enb <= 1'b1;
    end
  end

  // Frame watchdog: cleared by each published frame, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (o_frame_vld) begin
      stall_cnt <= '0;
    end else if (stall_cnt != STALL_MAX) begin
      stall_cnt <= stall_cnt + 20'd1;
    end
  end

  assign o_stall = (stall_cnt >= TIMEOUT_V);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: a scoreboard queue of expected
// frames is filled as scans are driven and drained by a frame monitor.
module tb_seg_scan_decoder;

  localparam int STABLE = 4;
  localparam int TMO    = 100;
  localparam int HOLD   = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  seg_enb = 6'h3F;
  logic        seg_dp = 1'b0;
  logic [6:0]  seg = 7'h00;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic [5:0]  o_blank;
  logic        o_frame_vld;
  logic        o_err_seg;
  logic        o_err_enb;
  logic        o_stall;

  typedef struct packed {
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  blank;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int frame_cnt = 0;
  int err_seg_cnt = 0;
  int err_enb_cnt = 0;

  seg_scan_decoder #(
    .STABLE_CYC (STABLE),
    .ENB_ACT_LOW(1'b1),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_seg_enb  (seg_enb),
    .i_seg_dp   (seg_dp),
    .i_seg      (seg),
    .o_digits   (o_digits),
    .o_dp       (o_dp),
    .o_blank    (o_blank),
    .o_frame_vld(o_frame_vld),
    .o_err_seg  (o_err_seg),
    .o_err_enb  (o_err_enb),
    .o_stall    (o_stall)
  );

  always #10 clk = ~clk;

  // Segment encoding of a BCD value as the display driver would emit it.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: seg_of = 7'b1111110;
      4'h1: seg_of = 7'b0110000;
      4'h2: seg_of = 7'b1101101;
      4'h3: seg_of = 7'b1111001;
      4'h4: seg_of = 7'b0110011;
      4'h5: seg_of = 7'b1011011;
      4'h6: seg_of = 7'b1011111;
      4'h7: seg_of = 7'b1110000;
      4'h8: seg_of = 7'b1111111;
      4'h9: seg_of = 7'b1111011;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  function automatic logic [41:0] segs_of(input logic [23:0] d);
    logic [41:0] s;
    s = '0;
    for (int k = 0; k < 6; k++) s[7*k +: 7] = seg_of(d[4*k +: 4]);
    return s;
  endfunction

  // Scoreboard consumer: every published frame must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_frame_vld === 1'b1) begin
        frame_t e;
        frame_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL frame_unexpected: got digits=%h dp=%b blank=%b, none expected",
                   o_digits, o_dp, o_blank);
        end else begin
          e = exp_q.pop_front();
          if ({o_digits, o_dp, o_blank} !== e) begin
            failures++;
            $display("FAIL frame: got digits=%h dp=%b blank=%b, want digits=%h dp=%b blank=%b",
                     o_digits, o_dp, o_blank, e.digits, e.dp, e.blank);
          end
        end
      end
      if (o_err_seg === 1'b1) err_seg_cnt++;
      if (o_err_enb === 1'b1) err_enb_cnt++;
    end
  end

  // Drive one bus value (enables given active-high) for a number of cycles.
  task automatic drive(input logic [5:0] enb_hi, input logic dp,
                       input logic [6:0] s, input int cycles);
    seg_enb = ~enb_hi;
    seg_dp  = dp;
    seg     = s;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    drive(6'h00, 1'b0, 7'h00, cycles);
  endtask

  task automatic scan(input logic [41:0] segs, input logic [5:0] dps,
                      input int first, input int last);
    for (int k = first; k <= last; k++)
      drive(6'(1 << k), dps[k], segs[7*k +: 7], HOLD);
  endtask

  task automatic push(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl);
    frame_t f;
    f.digits = d;
    f.dp     = dp;
    f.blank  = bl;
    exp_q.push_back(f);
  endtask

  // Bounded wait for all expected frames to appear.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d frames still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    idle(1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_digits, o_dp, o_blank} !== {24'hFFFFFF, 6'h00, 6'h3F}) begin
      failures++;
      $display("FAIL reset_outputs: got digits=%h dp=%b blank=%b, want FFFFFF 000000 111111",
               o_digits, o_dp, o_blank);
    end
    checks++;
    if ({o_frame_vld, o_err_seg, o_err_enb, o_stall} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_pulses: got %b, want 0000",
               {o_frame_vld, o_err_seg, o_err_enb, o_stall});
    end
    idle(8);
    expect_int("reset_no_frames", frame_cnt, 0);
    expect_int("reset_no_errors", err_seg_cnt + err_enb_cnt, 0);
  endtask

  task automatic test_clean_scan();
    int f0, s0, e0;
    f0 = frame_cnt; s0 = err_seg_cnt; e0 = err_enb_cnt;
    push(24'h054321, 6'b000100, 6'h00);
    scan(segs_of(24'h054321), 6'b000100, 0, 5);
    idle(2);
    drain("clean");
    expect_int("clean_frame_count", frame_cnt - f0, 1);
    expect_int("clean_errors", (err_seg_cnt - s0) + (err_enb_cnt - e0), 0);
  endtask

  task automatic test_glitch();
    int f0, s0, e0;
    logic [41:0] segs;
    f0 = frame_cnt; s0 = err_seg_cnt; e0 = err_enb_cnt;
    segs = segs_of(24'h987654);
    push(24'h987654, 6'h00, 6'h00);
    for (int k = 0; k < 6; k++) begin
      case (k % 3)
        0: drive(6'(1 << k), 1'b1, seg_of(4'h1), STABLE - 1);
        1: drive(6'b000011, 1'b0, seg_of(4'h2), STABLE - 1);
        default: drive(6'(1 << k), 1'b0, 7'b1001001, STABLE - 1);
      endcase
      drive(6'(1 << k), 1'b0, segs[7*k +: 7], HOLD);
    end
    idle(2);
    drain("glitch");
    expect_int("glitch_frame_count", frame_cnt - f0, 1);
    expect_int("glitch_no_errors", (err_seg_cnt - s0) + (err_enb_cnt - e0), 0);
  endtask

  task automatic test_bad_seg();
    int f0, s0, e0;
    logic [41:0] segs;
    f0 = frame_cnt; s0 = err_seg_cnt; e0 = err_enb_cnt;
    segs = segs_of(24'h560789);
    segs[21 +: 7] = 7'b1001001;
    push(24'h56E789, 6'h00, 6'h00);
    scan(segs, 6'h00, 0, 5);
    idle(2);
    drain("bad_seg");
    expect_int("bad_seg_pulses", err_seg_cnt - s0, 1);
    expect_int("bad_seg_no_enb_err", err_enb_cnt - e0, 0);
    expect_int("bad_seg_digit3", int'(o_digits[15:12]), 14);
    expect_int("bad_seg_frame_count", frame_cnt - f0, 1);
  endtask

  task automatic test_bad_enb();
    int f0, e0;
    f0 = frame_cnt; e0 = err_enb_cnt;
    drive(6'b000011, 1'b0, seg_of(4'h1), HOLD);
    idle(5);
    expect_int("bad_enb_pulses", err_enb_cnt - e0, 1);
    expect_int("bad_enb_no_frame", frame_cnt - f0, 0);
    // Slots 1..5 alone must not complete a frame if nothing was stored.
    scan(segs_of(24'h543210), 6'h00, 1, 5);
    idle(3);
    expect_int("bad_enb_no_store", frame_cnt - f0, 0);
    push(24'h543210, 6'h00, 6'h00);
    scan(segs_of(24'h543210), 6'h00, 0, 0);
    idle(2);
    drain("bad_enb");
    expect_int("bad_enb_frame_count", frame_cnt - f0, 1);
  endtask

  task automatic test_blank();
    int s0;
    s0 = err_seg_cnt;
    push(24'hF54321, 6'h00, 6'b100000);
    scan(segs_of(24'hF54321), 6'h00, 0, 5);
    idle(2);
    drain("blank");
    expect_int("blank_bit5", int'(o_blank[5]), 1);
    expect_int("blank_digit5", int'(o_digits[23:20]), 15);
    expect_int("blank_no_seg_err", err_seg_cnt - s0, 0);
  endtask

  task automatic test_stall();
    do_reset();
    repeat (TMO - 1) @(negedge clk);
    expect_int("stall_before_timeout", int'(o_stall), 0);
    @(negedge clk);
    expect_int("stall_at_timeout", int'(o_stall), 1);
    push(24'h112233, 6'h00, 6'h00);
    scan(segs_of(24'h112233), 6'h00, 0, 5);
    drain("stall");
    @(negedge clk);
    expect_int("stall_cleared", int'(o_stall), 0);
  endtask

  task automatic test_reset_mid();
    int f0;
    scan(segs_of(24'h111111), 6'h07, 0, 2);
    do_reset();
    expect_int("mid_reset_digits", (o_digits == 24'hFFFFFF) ? 1 : 0, 1);
    f0 = frame_cnt;
    scan(segs_of(24'h234567), 6'h00, 3, 5);
    idle(3);
    expect_int("mid_reset_partial_discarded", frame_cnt - f0, 0);
    push(24'h234567, 6'h00, 6'h00);
    scan(segs_of(24'h234567), 6'h00, 0, 2);
    idle(2);
    drain("reset_mid");
    expect_int("mid_reset_frame_count", frame_cnt - f0, 1);
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = frame_cnt;
    push(24'h135790, 6'h00, 6'h00);
    scan(segs_of(24'h135790), 6'h00, 0, 5);
    push(24'h864209, 6'b100001, 6'h00);
    scan(segs_of(24'h864209), 6'b100001, 0, 5);
    idle(2);
    drain("b2b");
    expect_int("b2b_frame_count", frame_cnt - f0, 2);
  endtask

  initial begin
    test_reset();
    test_clean_scan();
    idle(4);
    test_glitch();
    idle(4);
    test_bad_seg();
    idle(4);
    test_bad_enb();
    idle(4);
    test_blank();
    idle(4);
    test_stall();
    idle(4);
    test_reset_mid();
    idle(4);
    test_back_to_back();
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the six-digit multiplexed 7-segment display driver.
- Samples the scanned bus (digit enables, segments, decimal point) and filters scan-transition glitches.
- Decodes each lit digit back to BCD and publishes a complete 6-digit frame with a one-cycle valid strobe.
- Used in simulation benches and on-chip self-check of the NCO/counter/display path.

Parameters:
- STABLE_CYC, 4, consecutive cycles an enable pattern and its segment value must hold unchanged before capture (legal range 2..255).
- ENB_ACT_LOW, 1, 1 = digit enables active-low (6'b111110 selects digit 0), 0 = active-high.
- TIMEOUT_CYC, 1000000, cycles without any frame completion before o_stall asserts.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- i_seg_enb  input  6  scanned digit enables; bit k selects digit k
- i_seg_dp  input  1  decimal point, active-high
- i_seg  input  7  segments {a,b,c,d,e,f,g} on bits [6:0], active-high
- o_digits  output  24  decoded BCD; digit k on bits [4k+3:4k]
- o_dp  output  6  decimal point per digit
- o_blank  output  6  digit k captured with all segments off
- o_frame_vld  output  1  one-cycle pulse when o_digits/o_dp/o_blank update
- o_err_seg  output  1  one-cycle pulse: captured segment pattern not in the decode table
- o_err_enb  output  1  one-cycle pulse: stable enable pattern with more than one digit selected
- o_stall  output  1  level: no frame completed within TIMEOUT_CYC cycles

Behaviour:
- Input stage: all inputs registered once, with no metastability synchronizer (synchronous source). Enables are normalised to active-high internally.
- Stability filter: an 8-bit counter clears whenever {enb, dp, seg} differs from the previous registered sample, and otherwise increments, saturating at STABLE_CYC.
- Capture occurs on the cycle the counter reaches STABLE_CYC-1. Exactly one capture happens per stable interval; no recapture until the input changes.
- Enable pattern at capture:
  - All zero: ignored, no flags.
  - Exactly one bit set (one-hot): decode the segments into shadow slot k and set mask bit k.
  - Two or more bits set: o_err_enb pulses on the capture cycle; nothing is stored.
- Decode table for {a..g}:
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9.
  - 0000000 stores 4'hF with blank bit 1.
  - Any other pattern stores 4'hE, blank 0, and pulses o_err_seg on the capture cycle. The mask bit is still set.
- Recapturing a slot before the frame completes overwrites that slot. No error is raised.
- Frame completion: on the cycle after the mask becomes 6'b111111:
  - Shadow slots copy atomically to o_digits/o_dp/o_blank.
  - o_frame_vld pulses high for exactly 1 cycle.
  - The mask clears in the same cycle.
  - A capture landing in that same cycle sets its mask bit in the new, cleared mask.
- Latency: from the first cycle of a new input value, capture follows at +STABLE_CYC cycles, counting 1 register cycle plus STABLE_CYC-1 counting cycles.
- Stall: a 20-bit counter clears on o_frame_vld and otherwise increments, saturating.
  - o_stall = (counter >= TIMEOUT_CYC).
  - o_stall deasserts in the cycle after the next o_frame_vld.
- Reset values:
  - o_digits = 24'hFFFFFF, o_dp = 0, o_blank = 6'b111111.
  - o_frame_vld, o_err_seg, o_err_enb, o_stall = 0.
  - Mask, shadow registers and both counters are cleared.
- Reset mid-operation: a partial frame is discarded. The first frame after reset requires all six digits to be captured again.
- Internal control: FSM with states SCAN (accumulating) and PUBLISH (one cycle: copy and pulse) → SCAN.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release → o_digits=FFFFFF, o_blank=3F, no pulses.
- Clean scan: enb cycles 111110..011111, each held 10 cycles with digits 1,2,3,4,5,0 and dp on digit 2 → one o_frame_vld, o_digits=24'h054321, o_dp=6'b000100.
- Glitch rejection (STABLE_CYC=4): insert a 3-cycle wrong enable/segment value between digits → no capture from it and no error; the frame still equals the expected value.
- Bad patterns: segments 1001001 on digit 3 → o_err_seg pulse, o_digits[15:12]=E. Enable 111100 held 10 cycles → o_err_enb pulse and no store.
- Blank digit: segments 0000000 on digit 5 → o_blank[5]=1, o_digits[23:20]=F.
- Stall/reset: TIMEOUT_CYC=100 with scanning stopped → o_stall=1 at cycle 100; resume scanning → clears after the next frame. Assert rst_n low after 3 digits are captured → the next frame needs all 6 digits.
